// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the mesh router.
//   port_e        : port enumeration N=0, E=1, S=2, W=3, L=4
//   NUM_PORTS     : number of router ports
//   flit_field    : extract an arbitrary bit field from the low header bits
//   flit_dest_x/y : destination coordinate extraction
//   xy_route      : dimension-ordered (X first, then Y) routing decision
package noc_pkg;

  localparam int NUM_PORTS = 5;

  // Header fields are always taken from the low bits of a flit, so the
  // helpers only ever look at a 32-bit window of it.
  localparam int HDR_W = 32;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_S = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  function automatic logic [HDR_W-1:0] flit_field(input logic [HDR_W-1:0] hdr,
                                                  input int lsb,
                                                  input int width);
    logic [HDR_W-1:0] mask;
    mask = (HDR_W'(1) << width) - HDR_W'(1);
    return (hdr >> lsb) & mask;
  endfunction

  function automatic logic [HDR_W-1:0] flit_dest_x(input logic [HDR_W-1:0] hdr,
                                                   input int x_w);
    return flit_field(hdr, 0, x_w);
  endfunction

  function automatic logic [HDR_W-1:0] flit_dest_y(input logic [HDR_W-1:0] hdr,
                                                   input int x_w,
                                                   input int y_w);
    return flit_field(hdr, x_w, y_w);
  endfunction

  // X is resolved completely before Y; N is the +y direction.
  function automatic port_e xy_route(input logic [HDR_W-1:0] dest_x,
                                     input logic [HDR_W-1:0] dest_y,
                                     input logic [HDR_W-1:0] my_x,
                                     input logic [HDR_W-1:0] my_y);
    if (dest_x > my_x)      return PORT_E;
    else if (dest_x < my_x) return PORT_W;
    else if (dest_y > my_y) return PORT_N;
    else if (dest_y < my_y) return PORT_S;
    else                    return PORT_L;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: synchronous FIFO used as the input buffer of each router port.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write push_data (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
//   head_data   : oldest stored entry (valid while !empty)
module noc_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mesh_router_p.sv
// mesh_router_p: single-flit 5-port 2D-mesh router tile.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : per-input flit valid (index 0..4 = N,E,S,W,L)
//   in_ready   : per-input FIFO has space
//   in_data    : per-input flits, port p at [p*DATA_W +: DATA_W]
//   out_valid  : per-output registered flit valid
//   out_ready  : per-output downstream accept
//   out_data   : per-output flits, port p at [p*DATA_W +: DATA_W]
// Each input is buffered in a FIFO; the FIFO head is XY-routed and each
// output runs its own round-robin arbiter feeding an output register.
module mesh_router_p
  import noc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  output logic [NUM_PORTS-1:0]          out_valid,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] pop;
  logic [CNT_W-1:0]     fifo_count [NUM_PORTS];
  logic [DATA_W-1:0]    head_data  [NUM_PORTS];
  port_e                route      [NUM_PORTS];
  // grant[o][i]: output o takes the head of input i this cycle
  logic [NUM_PORTS-1:0] grant      [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    noc_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid[i] && !fifo_full[i]),
      .pop       (pop[i]),
      .push_data (in_data[i*DATA_W +: DATA_W]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i]),
      .count     (fifo_count[i]),
      .head_data (head_data[i])
    );

    // Ready comes from the registered count only, so a full FIFO stays
    // not-ready even in a cycle where it is being popped.
    assign in_ready[i] = (fifo_count[i] < CNT_W'(DEPTH));
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      route[i] = xy_route(flit_dest_x(HDR_W'(head_data[i]), X_W),
                          flit_dest_y(HDR_W'(head_data[i]), X_W, Y_W),
                          HDR_W'(MY_X), HDR_W'(MY_Y));
    end
  end

  // Each input routes to exactly one output, so OR-ing the grants can
  // never pop an input twice.
  always_comb begin
    pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) pop = pop | grant[o];
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0] req;
    logic [2:0]           winner;
    logic                 any_req;
    logic                 load;
    logic [2:0]           last_grant;
    logic                 valid_q;
    logic [DATA_W-1:0]    data_q;

    always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[i] = !fifo_empty[i] && (route[i] == port_e'(o));
      end
    end

    // Round-robin: scan from last_grant+1 around to last_grant itself.
    always_comb begin
      winner  = '0;
      any_req = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
        if (!any_req && req[(int'(last_grant) + k) % NUM_PORTS]) begin
          any_req = 1'b1;
          winner  = 3'((int'(last_grant) + k) % NUM_PORTS);
        end
      end
    end

    assign load     = any_req && (!valid_q || out_ready[o]);
    assign grant[o] = load ? (NUM_PORTS'(1) << winner) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q    <= 1'b0;
        data_q     <= '0;
        last_grant <= 3'(PORT_L);
      end else if (load) begin
        valid_q    <= 1'b1;
        data_q     <= head_data[winner];
        last_grant <= winner;
      end else if (out_ready[o]) begin
        valid_q    <= 1'b0;
      end
    end

    assign out_valid[o]                 = valid_q;
    assign out_data[o*DATA_W +: DATA_W] = data_q;
  end

endmodule

// File: tb/tb_mesh_router_p.sv
// tb_mesh_router_p: scoreboard bench for mesh_router_p at tile (1,1).
// Flits carry {src[2:0], seq[8:0], dest_y[1:0], dest_x[1:0]} so the
// monitor can tell which input a flit came from. Expected flits are kept
// per (source, output) pair, which captures per-input ordering without
// assuming anything about arbitration; arbitration order is checked
// separately in the contention scenario.
module tb_mesh_router_p;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int X_W    = 2;
  localparam int Y_W    = 2;
  localparam int MY_X   = 1;
  localparam int MY_Y   = 1;
  localparam int NP     = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NP-1:0]        in_valid = '0;
  logic [NP-1:0]        in_ready;
  logic [NP*DATA_W-1:0] in_data = '0;
  logic [NP-1:0]        out_valid;
  logic [NP-1:0]        out_ready = '0;
  logic [NP*DATA_W-1:0] out_data;

  always #5 clk = ~clk;

  mesh_router_p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .MY_X   (MY_X),
    .MY_Y   (MY_Y)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic [15:0] data;
    int          acc_cyc;
    bit          lat_chk;
  } exp_t;

  exp_t         expq [NP*NP][$];
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  int           fire_count = 0;
  int           seq = 0;
  bit           lat_mode = 0;
  bit           log_en = 0;
  int           e_log_src [$];
  int           e_log_cyc [$];
  logic [NP-1:0] prev_stall = '0;
  logic [15:0]  prev_data [NP];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference routing, straight from the XY rule for tile (MY_X, MY_Y).
  function automatic int ref_route(input int dx, input int dy);
    if (dx > MY_X) return 1;
    if (dx < MY_X) return 3;
    if (dy > MY_Y) return 0;
    if (dy < MY_Y) return 2;
    return 4;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_flit(input int p, input int dx, input int dy);
    in_data[p*DATA_W +: DATA_W] = {3'(p), 9'(seq), 2'(dy), 2'(dx)};
    seq++;
  endtask

  task automatic push_expect(input int i);
    exp_t        e;
    logic [15:0] d;
    d         = in_data[i*DATA_W +: DATA_W];
    e.data    = d;
    e.acc_cyc = cyc;
    e.lat_chk = lat_mode;
    expq[i*NP + ref_route(int'(d[1:0]), int'(d[3:2]))].push_back(e);
  endtask

  // Accept watcher: inputs are stable at negedge and are taken at the
  // following posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NP; i++) begin
        if (in_valid[i] && in_ready[i]) push_expect(i);
      end
    end
  end

  task automatic check_output();
    logic [15:0] d;
    int          src;
    exp_t        e;
    if (!rst_n) begin
      prev_stall = '0;
      return;
    end
    for (int o = 0; o < NP; o++) begin
      d = out_data[o*DATA_W +: DATA_W];
      if (prev_stall[o]) begin
        checks++;
        if (!(out_valid[o] && d == prev_data[o])) begin
          errors++;
          $display("[TB] FAIL hold_out%0d: valid=%0b data=%h, expected valid=1 data=%h",
                   o, out_valid[o], d, prev_data[o]);
        end
      end
      if (out_valid[o] && out_ready[o]) begin
        fire_count++;
        src = int'(d[15:13]);
        if (o == 1 && log_en) begin
          e_log_src.push_back(src);
          e_log_cyc.push_back(cyc);
        end
        checks++;
        if (src >= NP || expq[src*NP + o].size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_out%0d: got flit %h, expected no flit", o, d);
        end else begin
          e = expq[src*NP + o].pop_front();
          if (d !== e.data) begin
            errors++;
            $display("[TB] FAIL data_out%0d: got %h, expected %h", o, d, e.data);
          end
          if (e.lat_chk) check_int($sformatf("latency_out%0d", o), cyc - e.acc_cyc, 2);
        end
      end
      prev_stall[o] = out_valid[o] && !out_ready[o];
      prev_data[o]  = d;
    end
  endtask

  always @(negedge clk) check_output();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer the preset flit on each masked port and hold it until accepted.
  task automatic apply_stimulus(input logic [NP-1:0] mask);
    logic [NP-1:0] pend;
    int            budget;
    pend   = mask;
    budget = 0;
    in_valid = pend;
    while (pend != '0 && budget < 50) begin
      @(negedge clk);
      pend = pend & ~in_ready;
      @(posedge clk);
      #1;
      in_valid = pend;
      budget++;
    end
    if (pend != '0) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: pending=%b, expected 00000", pend);
    end
    in_valid = '0;
  endtask

  function automatic int queued_total();
    int t;
    t = 0;
    for (int q = 0; q < NP*NP; q++) t += expq[q].size();
    return t;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          f0;
    int          n_acc;
    bit          a;
    int          dests [5][2];
    int          budget;
    int          want_src [4];

    dests = '{'{2, 1}, '{0, 1}, '{1, 2}, '{1, 0}, '{1, 1}};
    want_src = '{0, 2, 3, 4};

    // Reset state
    #1;
    check_int("reset_out_valid", int'(out_valid), 0);
    check_int("reset_out_data", int'(out_data != '0), 0);
    check_int("reset_in_ready", int'(in_ready), 31);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Routing sweep from L with a free output: 2-cycle latency each
    out_ready = '1;
    lat_mode  = 1;
    for (int k = 0; k < 5; k++) begin
      f0 = fire_count;
      set_flit(4, dests[k][0], dests[k][1]);
      apply_stimulus(5'b10000);
      repeat (4) tick();
      check_int($sformatf("sweep_fire_%0d", k), fire_count - f0, 1);
    end
    lat_mode = 0;

    // Contention on E: two bursts, each must come out N,S,W,L back to back
    for (int b = 0; b < 2; b++) begin
      e_log_src.delete();
      e_log_cyc.delete();
      log_en = 1;
      set_flit(0, 2, 1);
      set_flit(2, 2, 1);
      set_flit(3, 2, 1);
      set_flit(4, 2, 1);
      apply_stimulus(5'b11101);
      repeat (8) tick();
      log_en = 0;
      check_int($sformatf("burst%0d_count", b), e_log_src.size(), 4);
      if (e_log_src.size() == 4) begin
        for (int k = 0; k < 4; k++) begin
          check_int($sformatf("burst%0d_order%0d", b, k), e_log_src[k], want_src[k]);
        end
        check_int($sformatf("burst%0d_back_to_back", b), e_log_cyc[3] - e_log_cyc[0], 3);
      end
    end

    // Backpressure and full FIFO on L -> E
    out_ready = 5'b11101;
    f0        = fire_count;
    n_acc     = 0;
    set_flit(4, 2, 1);
    in_valid  = 5'b10000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a = in_ready[4];
      @(posedge clk);
      #1;
      if (a) begin
        n_acc++;
        set_flit(4, 2, 1);
      end
    end
    check_int("full_accepted", n_acc, 5);
    check_int("full_in_ready_l", int'(in_ready[4]), 0);
    check_int("full_out_valid_e", int'(out_valid[1]), 1);
    out_ready = '1;
    budget    = 0;
    a         = 0;
    while (!a && budget < 20) begin
      @(negedge clk);
      a = in_ready[4];
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = '0;
    repeat (10) tick();
    check_int("drain_fires", fire_count - f0, 6);

    // Head-of-line: W blocked behind a full E register, N -> L unaffected
    out_ready = 5'b11101;
    set_flit(3, 2, 1);
    apply_stimulus(5'b01000);
    set_flit(3, 2, 1);
    apply_stimulus(5'b01000);
    repeat (3) tick();
    f0       = fire_count;
    lat_mode = 1;
    set_flit(0, 1, 1);
    apply_stimulus(5'b00001);
    repeat (4) tick();
    lat_mode = 0;
    check_int("hol_local_fire", fire_count - f0, 1);
    check_int("hol_e_still_valid", int'(out_valid[1]), 1);
    out_ready = '1;
    repeat (6) tick();

    // Reset with flits in flight
    out_ready = 5'b11101;
    for (int k = 0; k < 3; k++) begin
      set_flit(4, 2, 1);
      apply_stimulus(5'b10000);
    end
    repeat (2) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("midreset_out_valid", int'(out_valid), 0);
    check_int("midreset_in_ready", int'(in_ready), 31);
    check_int("midreset_out_data", int'(out_data != '0), 0);
    for (int q = 0; q < NP*NP; q++) expq[q].delete();
    repeat (2) tick();
    rst_n     = 1'b1;
    out_ready = '1;
    f0        = fire_count;
    repeat (10) tick();
    check_int("no_stale_flit", fire_count - f0, 0);

    // Randomised traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        set_flit(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      out_ready = NP'($urandom);
      tick();
    end
    in_valid  = '0;
    out_ready = '1;
    budget    = 0;
    while (queued_total() != 0 && budget < 100) begin
      tick();
      budget++;
    end
    repeat (3) tick();
    check_int("random_drain_empty", queued_total(), 0);
    check_int("final_out_valid", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
